// File: rtl/switch_pkg.sv
// Shared types and constants for the pulse packet link.
package switch_pkg;
  localparam int unsigned PKT_W    = 4;
  localparam int unsigned DEST_MSB = 3;
  localparam int unsigned DEST_LSB = 2;
  localparam int unsigned GAP_W    = 4;
  localparam int unsigned BIT_W    = 2;

  typedef logic [PKT_W-1:0] pkt_t;

  typedef enum logic [1:0] {S_IDLE, S_START, S_GAP, S_BIT} tx_state_t;
endpackage

// File: rtl/packet_serializer_if.sv
// Packet input handshake plus pulse-link outputs of the serializer.
interface packet_serializer_if #(
  parameter int unsigned CNT_W = 8
);
  import switch_pkg::*;

  logic             pkt_valid;
  pkt_t             pkt_data;
  logic             pkt_ready;
  logic             tx_start;
  logic             tx_0;
  logic             tx_1;
  logic             tx_busy;
  logic             tx_done;
  logic [CNT_W-1:0] tx_count;

  modport master (
    output pkt_valid, pkt_data,
    input  pkt_ready, tx_start, tx_0, tx_1, tx_busy, tx_done, tx_count
  );

  modport slave (
    input  pkt_valid, pkt_data,
    output pkt_ready, tx_start, tx_0, tx_1, tx_busy, tx_done, tx_count
  );
endinterface

// File: rtl/pkt_hold_reg.sv
// One-entry holding register; ready in is simply "entry empty".
module pkt_hold_reg
  import switch_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  input  pkt_t i_data,
  output logic o_ready,
  output logic o_valid,
  output pkt_t o_data,
  input  logic i_ready
);
  logic r_empty;
  pkt_t r_data;
  logic w_load;
  logic w_take;

  assign w_load = i_valid & r_empty;
  assign w_take = ~r_empty & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_empty <= 1'b1;
      r_data  <= '0;
    end else begin
      if (w_load) begin
        r_data  <= i_data;
        r_empty <= 1'b0;
      end else if (w_take) begin
        r_empty <= 1'b1;
      end
    end
  end

  assign o_ready = r_empty;
  assign o_valid = ~r_empty;
  assign o_data  = r_data;
endmodule

// File: rtl/packet_serializer.sv
// Serializes 4-bit packets into start / one-hot bit pulses, LSB first.
module packet_serializer
  import switch_pkg::*;
#(
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                fract_clk,
  input  logic                rst_n,
  packet_serializer_if.slave  bus
);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP == 0) ? 0 : GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PKT_W - 1);

  tx_state_t        r_state, w_state_nx;
  pkt_t             r_sh, w_sh_nx;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nx;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_cnt_nx;
  logic             r_ifg, w_ifg_nx;
  logic [CNT_W-1:0] r_count;
  logic             r_start, r_tx0, r_tx1, r_busy, r_done;
  logic             w_accept, w_hold_in_valid, w_hold_ready, w_hold_valid, w_hold_take;
  logic             w_last_bit;
  pkt_t             w_hold_data;

  assign w_accept        = bus.pkt_valid & w_hold_ready;
  assign w_hold_in_valid = bus.pkt_valid & (r_state != S_IDLE);
  assign w_last_bit      = (r_state == S_BIT) && (r_bit_cnt == BIT_LAST);

  pkt_hold_reg u_hold (
    .clk     (fract_clk),
    .rst_n   (rst_n),
    .i_valid (w_hold_in_valid),
    .i_data  (bus.pkt_data),
    .o_ready (w_hold_ready),
    .o_valid (w_hold_valid),
    .o_data  (w_hold_data),
    .i_ready (w_hold_take)
  );

  always_ff @(posedge fract_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // A waiting packet launches straight from the end of the frame, so the
  // inter-frame spacing is exactly GAP idle cycles.
  always_comb begin
    w_state_nx   = r_state;
    w_sh_nx      = r_sh;
    w_gap_cnt_nx = r_gap_cnt;
    w_bit_cnt_nx = r_bit_cnt;
    w_ifg_nx     = r_ifg;
    w_hold_take  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_hold_valid) begin
          w_sh_nx     = w_hold_data;
          w_hold_take = 1'b1;
          w_state_nx  = S_START;
        end else if (w_accept) begin
          w_sh_nx    = bus.pkt_data;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        w_bit_cnt_nx = '0;
        w_gap_cnt_nx = '0;
        w_ifg_nx     = 1'b0;
        w_state_nx   = (GAP > 0) ? S_GAP : S_BIT;
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          if (!r_ifg) begin
            w_state_nx = S_BIT;
          end else if (w_hold_valid) begin
            w_sh_nx     = w_hold_data;
            w_hold_take = 1'b1;
            w_state_nx  = S_START;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_gap_cnt_nx = r_gap_cnt + 1'b1;
        end
      end
      S_BIT: begin
        w_sh_nx      = r_sh >> 1;
        w_bit_cnt_nx = r_bit_cnt + 1'b1;
        w_gap_cnt_nx = '0;
        if (r_bit_cnt == BIT_LAST) begin
          w_ifg_nx = 1'b1;
          if (GAP > 0) begin
            w_state_nx = S_GAP;
          end else if (w_hold_valid) begin
            w_sh_nx     = w_hold_data;
            w_hold_take = 1'b1;
            w_state_nx  = S_START;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_state_nx = (GAP > 0) ? S_GAP : S_BIT;
        end
      end
    endcase
  end

  // Datapath and registered pulse outputs decoded from the current state.
  always_ff @(posedge fract_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh      <= '0;
      r_gap_cnt <= '0;
      r_bit_cnt <= '0;
      r_ifg     <= 1'b0;
      r_count   <= '0;
      r_start   <= 1'b0;
      r_tx0     <= 1'b0;
      r_tx1     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_sh      <= w_sh_nx;
      r_gap_cnt <= w_gap_cnt_nx;
      r_bit_cnt <= w_bit_cnt_nx;
      r_ifg     <= w_ifg_nx;
      r_start   <= (r_state == S_START);
      r_tx0     <= (r_state == S_BIT) & ~r_sh[0];
      r_tx1     <= (r_state == S_BIT) &  r_sh[0];
      r_busy    <= (r_state == S_START) | (r_state == S_BIT) | ((r_state == S_GAP) & ~r_ifg);
      r_done    <= w_last_bit;
      if (w_last_bit) r_count <= r_count + 1'b1;
    end
  end

  assign bus.pkt_ready = w_hold_ready;
  assign bus.tx_start  = r_start;
  assign bus.tx_0      = r_tx0;
  assign bus.tx_1      = r_tx1;
  assign bus.tx_busy   = r_busy;
  assign bus.tx_done   = r_done;
  assign bus.tx_count  = r_count;
endmodule

// File: tb/tb_packet_serializer.sv
// Directed bench: GAP=1 and GAP=0 serializers plus a pulse-decoding switch model.
module tb_packet_serializer;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  packet_serializer_if #(.CNT_W(8)) bus1 ();
  packet_serializer_if #(.CNT_W(2)) bus0 ();

  packet_serializer #(.GAP(1), .CNT_W(8)) u_dut1 (.fract_clk(clk), .rst_n(rst_n), .bus(bus1));
  packet_serializer #(.GAP(0), .CNT_W(2)) u_dut0 (.fract_clk(clk), .rst_n(rst_n), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Switch-side model: rebuild packets from pulses, one-hot write by destination.
  int         rx_idx;
  int         rx_cnt;
  logic [3:0] rx_sh;
  logic [3:0] rx_pout [32];
  logic [3:0] rx_wr   [32];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_idx <= 0;
      rx_cnt <= 0;
      rx_sh  <= '0;
    end else begin
      if (bus1.tx_start) rx_idx <= 0;
      else if (bus1.tx_0 || bus1.tx_1) begin
        rx_sh  <= {bus1.tx_1, rx_sh[3:1]};
        rx_idx <= rx_idx + 1;
        if (rx_idx == 3 && rx_cnt < 32) begin
          rx_pout[rx_cnt] <= {bus1.tx_1, rx_sh[3:1]};
          rx_wr[rx_cnt]   <= 4'b0001 << {bus1.tx_1, rx_sh[3]};
          rx_cnt          <= rx_cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {ready, start, tx_0, tx_1, done, busy}
  function automatic logic [5:0] obs1();
    return {bus1.pkt_ready, bus1.tx_start, bus1.tx_0, bus1.tx_1, bus1.tx_done, bus1.tx_busy};
  endfunction

  function automatic logic [5:0] obs0();
    return {bus0.pkt_ready, bus0.tx_start, bus0.tx_0, bus0.tx_1, bus0.tx_done, bus0.tx_busy};
  endfunction

  logic [5:0] exp_q[$];

  task automatic run_vec(input string tag, input bit sel);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      chk($sformatf("%s[%0d]", tag, k), 32'(sel ? obs0() : obs1()), 32'(exp_q[k]));
    end
  endtask

  task automatic send(input bit sel, input logic [3:0] p);
    int budget = 0;
    if (sel) begin bus0.pkt_valid = 1'b1; bus0.pkt_data = p; end
    else     begin bus1.pkt_valid = 1'b1; bus1.pkt_data = p; end
    while (!(sel ? bus0.pkt_ready : bus1.pkt_ready) && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("send_stall_bound", 32'(budget < 100), 32'd1);
    @(posedge clk); #1;
    if (sel) bus0.pkt_valid = 1'b0;
    else     bus1.pkt_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   budget;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus1.pkt_valid = 1'b0; bus1.pkt_data = '0;
    bus0.pkt_valid = 1'b0; bus0.pkt_data = '0;

    // 1: reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_obs1", 32'(obs1()), 32'h20);
    chk("rst_cnt1", 32'(bus1.tx_count), 32'd0);
    chk("rst_obs0", 32'(obs0()), 32'h20);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("idle_obs1", 32'(obs1()), 32'h20);
    chk("idle_cnt0", 32'(bus0.tx_count), 32'd0);

    // 2: GAP=1, single packet 4'b1011 accepted at edge N
    bus1.pkt_valid = 1'b1; bus1.pkt_data = 4'b1011;
    @(posedge clk); #1;
    bus1.pkt_valid = 1'b0;
    exp_q = '{6'b100000, 6'b110001, 6'b100001, 6'b100101, 6'b100001, 6'b100101,
              6'b100001, 6'b101001, 6'b100001, 6'b100111, 6'b100000};
    run_vec("t2", 1'b0);
    chk("t2_count", 32'(bus1.tx_count), 32'd1);

    // 3: back-to-back, 4'b0100 parked in hold while 4'b1011 is in flight
    bus1.pkt_valid = 1'b1; bus1.pkt_data = 4'b1011;
    @(posedge clk); #1;
    bus1.pkt_data = 4'b0100;
    @(posedge clk); #1;
    bus1.pkt_valid = 1'b0;
    exp_q = '{6'b010001, 6'b000001, 6'b000101, 6'b000001, 6'b000101, 6'b000001,
              6'b001001, 6'b000001, 6'b000111, 6'b100000, 6'b110001, 6'b100001,
              6'b101001, 6'b100001, 6'b101001, 6'b100001, 6'b100101, 6'b100001,
              6'b101011, 6'b100000};
    run_vec("t3", 1'b0);
    chk("t3_count", 32'(bus1.tx_count), 32'd3);

    // 4: GAP=0, 4'b0110 back-to-back pulses
    bus0.pkt_valid = 1'b1; bus0.pkt_data = 4'b0110;
    @(posedge clk); #1;
    bus0.pkt_valid = 1'b0;
    exp_q = '{6'b100000, 6'b110001, 6'b101001, 6'b100101, 6'b100101, 6'b101011, 6'b100000};
    run_vec("t4", 1'b1);
    chk("t4_count", 32'(bus0.tx_count), 32'd1);

    // 2-bit counter wraps 3 -> 0 after three more frames
    send(1'b1, 4'b0001);
    send(1'b1, 4'b0010);
    send(1'b1, 4'b0011);
    repeat (30) @(posedge clk);
    #1;
    chk("wrap_count", 32'(bus0.tx_count), 32'd0);

    // 5: reset mid-frame with a packet in hold
    bus1.pkt_valid = 1'b1; bus1.pkt_data = 4'b1111;
    @(posedge clk); #1;
    bus1.pkt_data = 4'b0101;
    @(posedge clk); #1;
    bus1.pkt_valid = 1'b0;
    chk("t5_hold_full", 32'(bus1.pkt_ready), 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    chk("t5_bit1_pulse", 32'(bus1.tx_1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_obs", 32'(obs1()), 32'h20);
    chk("t5_async_cnt", 32'(bus1.tx_count), 32'd0);
    bus1.pkt_valid = 1'b1; bus1.pkt_data = 4'b1010;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_valid_in_rst", 32'(obs1()), 32'h20);
    bus1.pkt_valid = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      seen = seen | bus1.tx_start | bus1.tx_0 | bus1.tx_1 | bus1.tx_done | bus1.tx_busy;
    end
    chk("t5_no_pulses", 32'(seen), 32'd0);
    chk("t5_ready", 32'(bus1.pkt_ready), 32'd1);
    chk("t5_count", 32'(bus1.tx_count), 32'd0);

    // 6: loopback of all 16 packets into the switch model
    for (int i = 0; i < 16; i++) send(1'b0, 4'(i));
    budget = 0;
    while (rx_cnt < 16 && budget < 400) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("t6_rx_count", 32'(rx_cnt), 32'd16);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] sent;
      sent = 4'(i);
      chk($sformatf("t6_pout[%0d]", i), 32'(rx_pout[i]), 32'(sent));
      chk($sformatf("t6_wr[%0d]", i), 32'(rx_wr[i]), 32'(4'b0001 << sent[3:2]));
    end
    chk("t6_count", 32'(bus1.tx_count), 32'd16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
